// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder.
package nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned NIB_BITS = 4;

  // Counter width for NIB steps; a single-nibble adder still needs one counter bit.
  function automatic int unsigned cnt_width(input int unsigned nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nibble_add.sv
// 4-bit combinational full-adder slice shared across all nibble steps.
module nibble_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder built from one 4-bit slice, one nibble per clock, LSB first.
// Optional subtract mode (sub port) is enabled by defining NIBBLE_ADD_SUB_EN.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int unsigned Nib  = WIDTH / NIB_BITS;
  localparam int unsigned CntW = cnt_width(Nib);
  localparam logic [CntW-1:0] LastCnt = CntW'(Nib - 1);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [3:0] slice_s;
  logic       slice_cout;

  // Operands shift right each step so the slice always sees the low nibble.
  nibble_add u_nibble_add (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          cnt_d   = '0;
`ifdef NIBBLE_ADD_SUB_EN
          // Two's complement subtract: invert B and inject a carry-in of one.
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        a_d = a_q >> NIB_BITS;
        b_d = b_q >> NIB_BITS;
        sum_d[NIB_BITS*cnt_q +: NIB_BITS] = slice_s;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          sum_d[WIDTH] = slice_cout;
          cnt_d        = '0;
          state_d      = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with a per-cycle transaction-level reference.
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              sub = 1'b0;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              in_ready;
  logic              out_valid;
  logic              busy;
  logic [WIDTH:0]    sum;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef NIBBLE_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: an operation is pending from accept until taken; the result
  // becomes visible NIB cycles after accept and is the plain arithmetic sum.
  bit             m_pend = 1'b0;
  int             m_rem = 0;
  logic [WIDTH:0] m_sum = '0;
  int             cyc = 0;
  bit             spacing_en = 1'b0;
  int             last_acc = -1;
  int             t5_acc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_pend = 1'b0;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset sum", sum, 0);
    end else begin
      chk("in_ready", in_ready, !m_pend);
      chk("busy", busy, m_pend);
      chk("out_valid", out_valid, m_pend && m_rem == 0);
      if (m_pend && m_rem == 0) chk("sum", sum, m_sum);
      if (!m_pend) begin
        if (in_valid) begin
          m_pend = 1'b1;
          m_rem  = NIB;
          m_sum  = {1'b0, a} + {1'b0, b};
`ifdef NIBBLE_ADD_SUB_EN
          if (sub) m_sum = {1'b0, a} + {1'b0, ~b} + 17'd1;
`endif
          if (spacing_en) begin
            t5_acc++;
            if (last_acc >= 0) chk("accept spacing", cyc - last_acc, NIB + 2);
            last_acc = cyc;
          end
        end
      end else if (m_rem > 0) begin
        m_rem--;
      end else if (out_ready) begin
        m_pend = 1'b0;
      end
    end
    if (!spacing_en) last_acc = -1;
  end

  task automatic start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic s);
    @(posedge clk); #1;
    a = av; b = bv; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sub = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle after take", in_ready, 1);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: basic add and latency
    start(16'h1234, 16'h4321, 1'b0);
    wait_valid(n);
    chk("t1 latency", n, 4);
    chk("t1 sum", sum, 17'h05555);
    take();

    // 2: carry ripples through every nibble
    start(16'hFFFF, 16'h0001, 1'b0);
    wait_valid(n);
    chk("t2 latency", n, 4);
    chk("t2 sum", sum, 17'h10000);
    take();

    // 3: result held under backpressure
    start(16'hA000, 16'h0BCD, 1'b0);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t3 hold sum", sum, 17'h0ABCD);
      chk("t3 hold valid", out_valid, 1);
      chk("t3 hold in_ready", in_ready, 0);
    end
    take();
    chk("t3 busy after take", busy, 0);

    // 4: reset mid-operation discards it
    start(16'h1234, 16'h1111, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t4 async in_ready", in_ready, 1);
    chk("t4 async busy", busy, 0);
    chk("t4 async sum", sum, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("t4 no output", out_valid, 0);
    end
    start(16'h0001, 16'h0001, 1'b0);
    wait_valid(n);
    chk("t4 latency", n, 4);
    chk("t4 sum", sum, 17'h00002);
    take();

    // 5: continuous in_valid with a free-running consumer
    spacing_en = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = 16'(32'hF00F + i * 32'h1357);
      b = 16'(32'h0FF1 ^ (i << 4));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t5 accepts", t5_acc, 4);
    spacing_en = 1'b0;
    out_ready  = 1'b0;

`ifdef NIBBLE_ADD_SUB_EN
    // 6: subtraction, with and without borrow
    start(16'h0005, 16'h0007, 1'b1);
    wait_valid(n);
    chk("t6 sub borrow", sum, 17'h0FFFE);
    take();
    start(16'h0007, 16'h0005, 1'b1);
    wait_valid(n);
    chk("t6 sub no borrow", sum, 17'h10002);
    take();
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
